fmul_pipe: RTL and testbench

- Parametrised next-generation FP32 multiplier for the FPU.
- Full IEEE-754 binary32 semantics: subnormal inputs and outputs, NaN/Inf, two rounding modes, exception flags.
- Configurable pipeline depth with a valid/ready handshake and stall support, plus a sideband tag carried alongside each operation.
- Sits between the issue logic and the FPU result bus.

---
 rtl/fmul_pipe.sv | 271 +++++++++++++++++++++++++++
 tb/tb_fmul_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe.sv
// fmul_pipe: pipelined IEEE-754 binary32 multiplier with valid/ready handshake.
// Steps: unpack/classify/exponent add -> 24x24 product -> normalise/round -> pack/flags.
// STAGES (1..4) selects which step boundaries get registers; the output is always registered.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   in_valid/in_ready         operand handshake (in_ready = global advance enable)
//   x1, x2, rm, in_tag        operands, rounding mode (0=RNE, 1=RTZ), sideband tag
//   out_valid/out_ready       result handshake
//   y, flags, out_tag         product, {nv, of, uf, nx}, returned tag
module fmul_pipe #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic             rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [3:0]       flags,
  output logic [TAG_W-1:0] out_tag
);

  // Boundary registers: 4 -> after 1,2,3; 3 -> after 1,2; 2 -> after 2; 1 -> none.
  localparam bit REG1 = (STAGES >= 3);
  localparam bit REG2 = (STAGES >= 2);
  localparam bit REG3 = (STAGES >= 4);

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_e;

  typedef struct packed {
    logic             sign;
    spec_e            spec;
    logic             nv;
    logic             rm;
    logic [TAG_W-1:0] tag;
    logic [9:0]       exp;   // unbiased, two's complement
    logic [23:0]      ma;
    logic [23:0]      mb;
  } s1_t;

  typedef struct packed {
    logic             sign;
    spec_e            spec;
    logic             nv;
    logic             rm;
    logic [TAG_W-1:0] tag;
    logic [9:0]       exp;
    logic [47:0]      prod;
  } s2_t;

  typedef struct packed {
    logic             sign;
    spec_e            spec;
    logic             nv;
    logic             rm;
    logic [TAG_W-1:0] tag;
    logic             ovf;
    logic             nx;
    logic             tiny;
    logic [30:0]      mag;   // rounded {exponent, fraction}
  } s3_t;

  // Leading-zero count of a 24-bit value (24 when zero).
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++) if (v[i]) lzc24 = 5'(23 - i);
  endfunction

  // Returns {unbiased exponent[9:0], normalised mantissa[23:0]}; subnormals get msb at bit 23.
  function automatic logic [33:0] unpack_op(input logic [31:0] v);
    logic [23:0] m;
    logic [9:0]  ex;
    logic [4:0]  lz;
    lz = lzc24({1'b0, v[22:0]});
    if (v[30:23] != 8'd0) begin
      m  = {1'b1, v[22:0]};
      ex = 10'(v[30:23]) - 10'd127;
    end else begin
      m  = {1'b0, v[22:0]} << lz;
      ex = 10'(-126) - 10'(lz);
    end
    unpack_op = {ex, m};
  endfunction

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Step 1: unpack, classify, add exponents
  logic [33:0] ua, ub;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  s1_t  s1_d, s1_q;
  logic v1_q;

  assign ua     = unpack_op(x1);
  assign ub     = unpack_op(x2);
  assign a_nan  = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
  assign b_nan  = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);
  assign a_snan = a_nan & ~x1[22];
  assign b_snan = b_nan & ~x2[22];
  assign a_inf  = (x1[30:23] == 8'hFF) && (x1[22:0] == 23'd0);
  assign b_inf  = (x2[30:23] == 8'hFF) && (x2[22:0] == 23'd0);
  assign a_zero = (x1[30:0] == 31'd0);
  assign b_zero = (x2[30:0] == 31'd0);

  always_comb begin
    s1_d      = '0;
    s1_d.sign = x1[31] ^ x2[31];
    s1_d.rm   = rm;
    s1_d.tag  = in_tag;
    s1_d.exp  = ua[33:24] + ub[33:24];
    s1_d.ma   = ua[23:0];
    s1_d.mb   = ub[23:0];
    s1_d.spec = SP_NONE;
    if (a_nan | b_nan) begin
      s1_d.spec = SP_NAN;
      s1_d.nv   = a_snan | b_snan;
    end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
      s1_d.spec = SP_NAN;
      s1_d.nv   = 1'b1;
    end else if (a_inf | b_inf) begin
      s1_d.spec = SP_INF;
    end else if (a_zero | b_zero) begin
      s1_d.spec = SP_ZERO;
    end
  end

  if (REG1) begin : g_r1
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        v1_q <= 1'b0;
        s1_q <= '0;
      end else if (en) begin
        v1_q <= in_valid;
        s1_q <= s1_d;
      end
    end
  end else begin : g_c1
    assign v1_q = in_valid;
    assign s1_q = s1_d;
  end

  // Step 2: mantissa product
  s2_t  s2_d, s2_q;
  logic v2_q;

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.spec = s1_q.spec;
    s2_d.nv   = s1_q.nv;
    s2_d.rm   = s1_q.rm;
    s2_d.tag  = s1_q.tag;
    s2_d.exp  = s1_q.exp;
    s2_d.prod = 48'(s1_q.ma) * 48'(s1_q.mb);
  end

  if (REG2) begin : g_r2
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        v2_q <= 1'b0;
        s2_q <= '0;
      end else if (en) begin
        v2_q <= v1_q;
        s2_q <= s2_d;
      end
    end
  end else begin : g_c2
    assign v2_q = v1_q;
    assign s2_q = s2_d;
  end

  // Step 3: normalise, denormalise when tiny, round
  s3_t               s3_d, s3_q;
  logic              v3_q;
  logic [47:0]       pn;
  logic signed [9:0] be, sh;
  logic [5:0]        sh_c;
  logic [95:0]       wide;
  logic [23:0]       mant;
  logic              guard, sticky, inc, tiny;
  logic [7:0]        efield;

  always_comb begin
    pn     = s2_q.prod[47] ? s2_q.prod : {s2_q.prod[46:0], 1'b0};
    be     = $signed(s2_q.exp) + $signed(10'(s2_q.prod[47])) + 10'sd127;
    tiny   = (be < 10'sd1);
    sh     = 10'sd1 - be;
    sh_c   = tiny ? ((sh > 10'sd48) ? 6'd48 : 6'(sh)) : 6'd0;
    wide   = {pn, 48'd0} >> sh_c;
    mant   = wide[95:72];
    guard  = wide[71];
    sticky = |wide[70:0];
    inc    = ~s2_q.rm & guard & (sticky | mant[0]);
    // Hidden bit of a normal mantissa adds the final 1 to the exponent field;
    // a round-up carry ripples into the exponent the same way.
    efield = tiny ? 8'd0 : 8'(be - 10'sd1);
    s3_d      = '0;
    s3_d.sign = s2_q.sign;
    s3_d.spec = s2_q.spec;
    s3_d.nv   = s2_q.nv;
    s3_d.rm   = s2_q.rm;
    s3_d.tag  = s2_q.tag;
    s3_d.mag  = {efield, 23'd0} + 31'(mant) + 31'(inc);
    s3_d.ovf  = (be > 10'sd254) | (s3_d.mag[30:23] == 8'hFF);
    s3_d.nx   = guard | sticky;
    s3_d.tiny = tiny;
  end

  if (REG3) begin : g_r3
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        v3_q <= 1'b0;
        s3_q <= '0;
      end else if (en) begin
        v3_q <= v2_q;
        s3_q <= s3_d;
      end
    end
  end else begin : g_c3
    assign v3_q = v2_q;
    assign s3_q = s3_d;
  end

  // Step 4: pack result and flags
  logic [31:0] y_d;
  logic [3:0]  flags_d;

  always_comb begin
    y_d     = '0;
    flags_d = '0;
    case (s3_q.spec)
      SP_NAN: begin
        y_d     = 32'h7FC0_0000;
        flags_d = {s3_q.nv, 3'b000};
      end
      SP_INF:  y_d = {s3_q.sign, 8'hFF, 23'd0};
      SP_ZERO: y_d = {s3_q.sign, 31'd0};
      default: begin
        if (s3_q.ovf) begin
          y_d     = s3_q.rm ? {s3_q.sign, 31'h7F7F_FFFF} : {s3_q.sign, 31'h7F80_0000};
          flags_d = 4'b0101;
        end else begin
          y_d     = {s3_q.sign, s3_q.mag};
          flags_d = {2'b00, s3_q.tiny & s3_q.nx, s3_q.nx};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      y         <= '0;
      flags     <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= v3_q;
      y         <= y_d;
      flags     <= flags_d;
      out_tag   <= s3_q.tag;
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe; three instances (STAGES = 1, 3, 4) exercised one at a time.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  in_valid, in_ready, rm, out_valid, out_ready;
  logic [31:0] x1 [3];
  logic [31:0] x2 [3];
  logic [31:0] y [3];
  logic [3:0]  in_tag [3];
  logic [3:0]  flags [3];
  logic [3:0]  out_tag [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fmul_pipe #(.STAGES((g == 0) ? 1 : ((g == 1) ? 3 : 4)), .TAG_W(4)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .x1(x1[g]), .x2(x2[g]), .rm(rm[g]), .in_tag(in_tag[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .y(y[g]), .flags(flags[g]), .out_tag(out_tag[g])
    );
  end

  typedef struct {
    logic [31:0] y;
    logic [3:0]  flags;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        r;
    logic [31:0] y;
    logic [3:0]  f;
  } vec_t;

  // flags = {nv, of, uf, nx}
  vec_t vecs [16] = '{
    '{32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'h0},
    '{32'h3F800800, 32'h3F800800, 1'b0, 32'h3F801000, 4'h1},
    '{32'h3F800001, 32'h3F800001, 1'b1, 32'h3F800002, 4'h1},
    '{32'h7F7FFFFF, 32'h40000000, 1'b0, 32'h7F800000, 4'h5},
    '{32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F7FFFFF, 4'h5},
    '{32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'h8},
    '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8},
    '{32'h00800000, 32'h3F000000, 1'b0, 32'h00400000, 4'h0},
    '{32'h00000001, 32'h3F000000, 1'b0, 32'h00000000, 4'h3},
    '{32'h00000003, 32'h3F000000, 1'b0, 32'h00000002, 4'h3},
    '{32'hFFC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0},
    '{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'h0},
    '{32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, 4'h0},
    '{32'h007FFFFF, 32'h3F800001, 1'b0, 32'h00800000, 4'h3},
    '{32'h00000003, 32'h3F000000, 1'b1, 32'h00000001, 4'h3},
    '{32'hBFC00000, 32'h40000000, 1'b0, 32'hC0400000, 4'h0}
  };

  // Backpressure operands, each multiplied by 2.0
  logic [31:0] bp_a [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] bp_y [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                            32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

  exp_t sb [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cur = 0;
  bit   bp_seen;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int st_of(input int c);
    return (c == 0) ? 1 : ((c == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s inst=%0d: got %h, expected %h", nm, cur, act, expv);
    end
  endtask

  // Issue one op on the active instance; the expectation is queued at the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic r,
                      input logic [3:0] t, input logic [31:0] ey, input logic [3:0] ef,
                      input bit lat);
    exp_t e;
    bit   done;
    done = 1'b0;
    in_valid[cur] = 1'b1;
    x1[cur] = a;
    x2[cur] = b;
    rm[cur] = r;
    in_tag[cur] = t;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready[cur]) begin
        e.y = ey; e.flags = ef; e.tag = t; e.acc = cyc; e.lat = lat;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("accept_timeout", 32'(done), 32'd1);
    in_valid[cur] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares the presented result against the queue head every cycle it is shown
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 3; i++) begin
        if (out_valid[i]) begin
          if (i != cur || sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output inst=%0d: got y=%h tag=%h, expected no result", i, y[i], out_tag[i]);
          end else begin
            mon_e = sb[0];
            chk("y", y[i], mon_e.y);
            chk("flags", 32'(flags[i]), 32'(mon_e.flags));
            chk("tag", 32'(out_tag[i]), 32'(mon_e.tag));
            if (mon_e.lat) chk("latency", 32'(cyc - mon_e.acc), 32'(st_of(cur)));
            if (out_ready[i]) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    in_valid  = '0;
    rm        = '0;
    out_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      x1[i] = '0; x2[i] = '0; in_tag[i] = '0;
    end
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cur = i;
      chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
      chk("rst_y", y[i], 32'd0);
      chk("rst_flags", 32'(flags[i]), 32'd0);
      chk("rst_out_tag", 32'(out_tag[i]), 32'd0);
      chk("rst_in_ready", 32'(in_ready[i]), 32'd1);
    end
    rstn = 1'b1;

    for (int c = 0; c < 3; c++) begin
      cur = c;
      @(posedge clk); #1;

      // Directed vectors, back-to-back; first one also checks latency
      for (int v = 0; v < 16; v++)
        send(vecs[v].a, vecs[v].b, vecs[v].r, 4'(v + 5), vecs[v].y, vecs[v].f, v == 0);
      drain();

      // Backpressure: 8 back-to-back ops, first result stalled for 6 cycles
      bp_seen = 1'b0;
      fork
        begin
          for (int k = 0; k < 8; k++)
            send(bp_a[k], 32'h40000000, 1'b0, 4'(15 - k), bp_y[k], 4'h0, 1'b0);
        end
        begin
          for (int k = 0; k < 100 && !bp_seen; k++) begin
            @(posedge clk); #1;
            if (out_valid[cur]) bp_seen = 1'b1;
          end
          chk("bp_first_result", 32'(bp_seen), 32'd1);
          out_ready[cur] = 1'b0;
          repeat (6) @(posedge clk);
          #1;
          chk("bp_held_ops", 32'(sb.size()), 32'(st_of(cur)));
          chk("bp_in_ready_low", 32'(in_ready[cur]), 32'd0);
          out_ready[cur] = 1'b1;
        end
      join
      drain();

      // Reset with three ops in flight
      if (st_of(c) >= 3) begin
        for (int k = 0; k < 3; k++)
          send(32'h3FC00000, 32'h40000000, 1'b0, 4'(k + 1), 32'h40400000, 4'h0, 1'b0);
        #1 rstn = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid[cur]), 32'd0);
        chk("async_rst_y", y[cur], 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_ghost_after_rst", 32'(out_valid[cur]), 32'd0);
        send(32'h40400000, 32'h40400000, 1'b0, 4'hA, 32'h41100000, 4'h0, 1'b1);
        drain();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
